// File: rtl/program_loader.sv
// program_loader: streams RAM_BYTES program bytes from the pins into RAM via bus/MAR/RAM strobes.
// Optional build macro: LOADER_CHECKSUM_EN adds the running byte-sum accumulator on checksum.
module program_loader #(
    parameter int RAM_BYTES = 16,
    parameter int ADDR_W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              load_abort,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [7:0]        bus_out,
    output logic              bus_oe,
    output logic              n_lma,
    output logic              n_lmd,
    output logic              n_lr,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] addr,
    output logic [7:0]        checksum
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_BYTE,
        DRV_ADDR,
        DRV_DATA,
        WRITE,
        DONE
    } state_e;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_BYTES - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        byte_q, byte_d;
    logic              start_load, write_cyc;

    logic              in_ready_q, bus_oe_q, n_lma_q, n_lmd_q, n_lr_q, busy_q, done_q;
    logic [7:0]        bus_out_q;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        byte_d     = byte_q;
        start_load = 1'b0;
        write_cyc  = 1'b0;
        if (load_abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (load_start) begin
                        start_load = 1'b1;
                        state_d    = WAIT_BYTE;
                        addr_d     = '0;
                    end
                end
                WAIT_BYTE: begin
                    if (in_valid) begin
                        byte_d  = in_data;
                        state_d = DRV_ADDR;
                    end
                end
                DRV_ADDR: state_d = DRV_DATA;
                DRV_DATA: state_d = WRITE;
                WRITE: begin
                    write_cyc = 1'b1;
                    addr_d    = addr_q + ADDR_W'(1);
                    state_d   = (addr_q == LAST_ADDR) ? DONE : WAIT_BYTE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state and registered, so they change with the state
    // on the same edge and never glitch.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            byte_q     <= 8'h00;
            in_ready_q <= 1'b0;
            bus_oe_q   <= 1'b0;
            bus_out_q  <= 8'h00;
            n_lma_q    <= 1'b1;
            n_lmd_q    <= 1'b1;
            n_lr_q     <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            byte_q     <= byte_d;
            in_ready_q <= (state_d == WAIT_BYTE);
            bus_oe_q   <= (state_d == DRV_ADDR) || (state_d == DRV_DATA);
            if (state_d == DRV_ADDR) begin
                bus_out_q <= 8'(addr_d);
            end else if (state_d == DRV_DATA) begin
                bus_out_q <= byte_q;
            end else begin
                bus_out_q <= 8'h00;
            end
            n_lma_q    <= (state_d != DRV_ADDR);
            n_lmd_q    <= (state_d != DRV_DATA);
            n_lr_q     <= (state_d != WRITE);
            busy_q     <= (state_d == WAIT_BYTE) || (state_d == DRV_ADDR) ||
                          (state_d == DRV_DATA)  || (state_d == WRITE);
            done_q     <= (state_d == DONE);
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] sum_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= 8'h00;
        end else if (start_load) begin
            sum_q <= 8'h00;
        end else if (write_cyc) begin
            sum_q <= sum_q + byte_q;
        end
    end

    assign checksum = sum_q;
`else
    assign checksum = 8'h00;
`endif

    // Abort must refuse a byte in the same cycle, so it masks the registered ready directly.
    assign in_ready = in_ready_q & ~load_abort;
    assign bus_out  = bus_out_q;
    assign bus_oe   = bus_oe_q;
    assign n_lma    = n_lma_q;
    assign n_lmd    = n_lmd_q;
    assign n_lr     = n_lr_q;
    assign cpu_hold = busy_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign addr     = addr_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: a vector table for single-cycle behaviour plus hand-written
// multi-cycle sequences (full load, stall, abort, reset mid-load, reload, 4-entry wrap).
module tb_program_loader;

    logic       clk;
    logic       rst;
    logic       load_start, load_abort, in_valid;
    logic [7:0] in_data;
    logic       in_ready, bus_oe, n_lma, n_lmd, n_lr, cpu_hold, busy, done;
    logic [7:0] bus_out, checksum;
    logic [3:0] addr;

    logic       b_start, b_abort, b_valid;
    logic [7:0] b_data;
    logic       b_ready, b_oe, b_lma, b_lmd, b_lr, b_hold, b_busy, b_done;
    logic [7:0] b_bus, b_sum;
    logic [1:0] b_addr;

    int n_checks = 0;
    int n_fail   = 0;

    program_loader #(.RAM_BYTES(16), .ADDR_W(4)) dut (
        .clk(clk), .rst(rst), .load_start(load_start), .load_abort(load_abort),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .bus_out(bus_out), .bus_oe(bus_oe), .n_lma(n_lma), .n_lmd(n_lmd), .n_lr(n_lr),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .addr(addr), .checksum(checksum)
    );

    program_loader #(.RAM_BYTES(4), .ADDR_W(2)) dut_small (
        .clk(clk), .rst(rst), .load_start(b_start), .load_abort(b_abort),
        .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
        .bus_out(b_bus), .bus_oe(b_oe), .n_lma(b_lma), .n_lmd(b_lmd), .n_lr(b_lr),
        .cpu_hold(b_hold), .busy(b_busy), .done(b_done), .addr(b_addr), .checksum(b_sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    typedef struct {
        logic       start;
        logic       abort;
        logic       valid;
        logic [7:0] data;
        logic       rdy;
        logic       oe;
        logic [7:0] bus;
        logic       lma;
        logic       lmd;
        logic       lr;
        logic       bsy;
        logic       dn;
        logic [3:0] addr;
        logic       chk_addr;
    } vec_t;

    vec_t vecs[11];

    localparam logic [31:0] IDLE_O  = 32'({1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    localparam logic [31:0] WAIT_O  = 32'({1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0});
    localparam logic [31:0] WRITE_O = 32'({1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0});
    localparam logic [31:0] DONE_O  = 32'({1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1});

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] obs_a();
        return 32'({in_ready, bus_oe, bus_out, n_lma, n_lmd, n_lr, cpu_hold, busy, done});
    endfunction

    // cpu_hold is expected to equal busy in every state.
    function automatic logic [31:0] ex(input logic rdy, input logic oe, input logic [7:0] bus,
                                       input logic lma, input logic lmd, input logic lr,
                                       input logic bsy, input logic dn);
        return 32'({rdy, oe, bus, lma, lmd, lr, bsy, bsy, dn});
    endfunction

    function automatic logic [7:0] exp_sum(input logic [7:0] s);
`ifdef LOADER_CHECKSUM_EN
        return s;
`else
        return 8'h00 & s;
`endif
    endfunction

    // Starts in WAIT_BYTE; hands over one byte and checks the address/data/write strobe cycles.
    task automatic feed_byte(input logic [7:0] d, input int a);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
        check("feed_addr_phase", obs_a(), ex(1'b0, 1'b1, 8'(a), 1'b0, 1'b1, 1'b1, 1'b1, 1'b0));
        step();
        check("feed_data_phase", obs_a(), ex(1'b0, 1'b1, d, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0));
        step();
        check("feed_write_phase", obs_a(), WRITE_O);
        step();
    endtask

    initial begin
        logic [31:0] e;
        logic [7:0]  bvals[4];

        rst = 1'b0;
        load_start = 1'b0; load_abort = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        b_start = 1'b0; b_abort = 1'b0; b_valid = 1'b0; b_data = 8'h00;

        // Reset: asserted before any clock edge, outputs must already be at reset values.
        #1 rst = 1'b1;
        #2;
        check("reset_async_outputs", obs_a(), IDLE_O);
        check("reset_async_addr", 32'(addr), 32'd0);
        step();
        step();
        rst = 1'b0;
        step();
        check("reset_released_outputs", obs_a(), IDLE_O);
        check("reset_released_checksum", 32'(checksum), 32'h00);

        // Vector table: inputs held across one edge, outputs sampled 1 time unit after it.
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd1, 1'b1};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd1, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd1, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 8'h77, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1};

        for (int i = 0; i < 11; i++) begin
            load_start = vecs[i].start;
            load_abort = vecs[i].abort;
            in_valid   = vecs[i].valid;
            in_data    = vecs[i].data;
            step();
            check($sformatf("vec%0d_outputs", i), obs_a(),
                  ex(vecs[i].rdy, vecs[i].oe, vecs[i].bus, vecs[i].lma, vecs[i].lmd,
                     vecs[i].lr, vecs[i].bsy, vecs[i].dn));
            if (vecs[i].chk_addr) check($sformatf("vec%0d_addr", i), 32'(addr), 32'(vecs[i].addr));
        end
        load_start = 1'b0; load_abort = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        step();
        check("idle_after_table", obs_a(), IDLE_O);

        // Full load of bytes 0x00..0x0F with in_valid held high; cycle c counts edges after start.
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        in_valid   = 1'b1;
        for (int c = 1; c <= 64; c++) begin
            int k;
            k = (c - 1) / 4;
            in_data = 8'(k);
            step();
            case (c % 4)
                1: e = ex(1'b0, 1'b1, 8'(k), 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
                2: e = ex(1'b0, 1'b1, 8'(k), 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
                3: e = WRITE_O;
                default: e = (c == 64) ? DONE_O : WAIT_O;
            endcase
            check($sformatf("full_load_c%0d", c), obs_a(), e);
        end
        in_valid = 1'b0;
        check("full_load_addr_wrapped", 32'(addr), 32'd0);
        check("full_load_checksum", 32'(checksum), 32'(exp_sum(8'h78)));

        // Reload from DONE, stall 7 cycles at address 3, then finish with 0xFF bytes.
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        check("reload_outputs", obs_a(), WAIT_O);
        check("reload_addr", 32'(addr), 32'd0);
        check("reload_checksum", 32'(checksum), 32'h00);
        for (int i = 0; i < 3; i++) feed_byte(8'hFF, i);
        for (int s = 0; s < 7; s++) begin
            step();
            check($sformatf("stall_outputs_%0d", s), obs_a(), WAIT_O);
            check($sformatf("stall_addr_%0d", s), 32'(addr), 32'd3);
        end
        for (int i = 3; i < 16; i++) feed_byte(8'hFF, i);
        check("reload_done", obs_a(), DONE_O);
        check("reload_done_addr", 32'(addr), 32'd0);
        check("reload_checksum_ff", 32'(checksum), 32'(exp_sum(8'hF0)));

        // Abort together with a valid byte in WAIT_BYTE at address 9.
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        for (int i = 0; i < 9; i++) feed_byte(8'(8'h40 + i), i);
        check("abort_pre_addr", 32'(addr), 32'd9);
        load_abort = 1'b1;
        in_valid   = 1'b1;
        in_data    = 8'h55;
        #1;
        check("abort_ready_forced_low", 32'(in_ready), 32'd0);
        step();
        load_abort = 1'b0;
        in_valid   = 1'b0;
        #1;
        check("abort_idle", obs_a(), IDLE_O);
        step();
        check("abort_no_strobe", obs_a(), IDLE_O);

        // Asynchronous reset while driving data at address 5.
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        for (int i = 0; i < 5; i++) feed_byte(8'(i), i);
        in_valid = 1'b1;
        in_data  = 8'hEE;
        step();
        in_valid = 1'b0;
        step();
        check("rst_mid_drv_data", obs_a(), ex(1'b0, 1'b1, 8'hEE, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0));
        #1 rst = 1'b1;
        #1;
        check("rst_mid_outputs", obs_a(), IDLE_O);
        check("rst_mid_addr", 32'(addr), 32'd0);
        check("rst_mid_checksum", 32'(checksum), 32'h00);
        step();
        rst = 1'b0;
        for (int s = 0; s < 3; s++) begin
            step();
            check($sformatf("rst_release_idle_%0d", s), obs_a(), IDLE_O);
        end

        // Four-entry instance: address sequence 0,1,2,3 then wrap to 0 with done.
        bvals[0] = 8'h10; bvals[1] = 8'h20; bvals[2] = 8'h30; bvals[3] = 8'h40;
        b_start = 1'b1;
        step();
        b_start = 1'b0;
        check("wrap_start_addr", 32'(b_addr), 32'd0);
        for (int k = 0; k < 4; k++) begin
            b_valid = 1'b1;
            b_data  = bvals[k];
            step();
            b_valid = 1'b0;
            step();
            step();
            step();
            check($sformatf("wrap_addr_done_%0d", k), 32'({b_addr, b_done}),
                  32'({2'((k + 1) % 4), (k == 3) ? 1'b1 : 1'b0}));
        end
        check("wrap_hold_released", 32'({b_hold, b_busy}), 32'd0);
        check("wrap_checksum", 32'(b_sum), 32'(exp_sum(8'hA0)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
